// File: rtl/bch_error_injector.sv
// Channel-error stage: takes one codeword, flips a configurable number of distinct
// LFSR-chosen bits, and hands out the corrupted word together with its error mask.
module bch_error_injector #(
  parameter int          N       = 15,
  parameter int          MAX_ERR = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_enable,
  input  logic [7:0]   cfg_num_errors,
  input  logic         cfg_seed_load,
  input  logic [15:0]  cfg_seed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [N-1:0] out_err_mask,
  output logic [3:0]   out_err_count,
  output logic         busy,
  output logic [15:0]  stat_words,
  output logic [1:0]   dbg_state
);

  // Handshakes: a word moves on a port only in a cycle where valid and ready are
  // both high at the rising edge; valid never waits for ready.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PICK = 2'd1, S_OUT = 2'd2} state_t;

  localparam logic [15:0] TAPS = 16'hB400;

  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [N-1:0]   word_q, word_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [4:0]     tgt_q, tgt_d;
  logic [5:0]     rej_q, rej_d;
  logic [N-1:0]   odata_q, odata_d;
  logic [N-1:0]   omask_q, omask_d;
  logic [3:0]     ocnt_q, ocnt_d;
  logic [15:0]    stat_q, stat_d;

  logic [3:0]     pos;
  logic [N-1:0]   cand_oh;
  logic [N-1:0]   free_v;
  logic [N-1:0]   free_oh;
  logic [N-1:0]   take;
  logic [N-1:0]   new_mask;
  logic [4:0]     cnt_inc;
  logic [4:0]     tgt_sel;
  logic           pos_ok;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  always_comb begin
    pos = lfsr_q[3:0];
    for (int i = 0; i < N; i++) begin
      cand_oh[i] = (pos == 4'(i));
    end
    // Out-of-range positions give an all-zero one-hot and are rejected.
    pos_ok  = (|cand_oh) && !(|(cand_oh & mask_q));
    free_v  = ~mask_q;
    free_oh = free_v & (~free_v + {{(N-1){1'b0}}, 1'b1});
    cnt_inc = cnt_q + 5'd1;
    if (cfg_num_errors > 8'(MAX_ERR)) tgt_sel = 5'(MAX_ERR);
    else                              tgt_sel = cfg_num_errors[4:0];
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_step(lfsr_q);
    word_d   = word_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    rej_d    = rej_q;
    odata_d  = odata_q;
    omask_d  = omask_q;
    ocnt_d   = ocnt_q;
    stat_d   = stat_q;
    take     = '0;
    new_mask = mask_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_seed_load) lfsr_d = (cfg_seed == 16'h0000) ? SEED : cfg_seed;
        if (in_valid) begin
          word_d = in_data;
          mask_d = '0;
          cnt_d  = '0;
          rej_d  = '0;
          tgt_d  = cfg_enable ? tgt_sel : 5'd0;
          if (cfg_enable && (tgt_sel != 5'd0)) begin
            state_d = S_PICK;
          end else begin
            state_d = S_OUT;
            odata_d = in_data;
            omask_d = '0;
            ocnt_d  = '0;
          end
        end
      end
      S_PICK: begin
        if (pos_ok)              take = cand_oh;
        else if (rej_q == 6'd63) take = free_oh;
        if (|take) begin
          new_mask = mask_q | take;
          mask_d   = new_mask;
          cnt_d    = cnt_inc;
          rej_d    = '0;
          if (cnt_inc == tgt_q) begin
            state_d = S_OUT;
            odata_d = word_q ^ new_mask;
            omask_d = new_mask;
            ocnt_d  = cnt_inc[3:0];
          end
        end else begin
          rej_d = rej_q + 6'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          stat_d  = stat_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      word_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      rej_q   <= '0;
      odata_q <= '0;
      omask_q <= '0;
      ocnt_q  <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      rej_q   <= rej_d;
      odata_q <= odata_d;
      omask_q <= omask_d;
      ocnt_q  <= ocnt_d;
      stat_q  <= stat_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE) && !rst;
  assign out_valid     = (state_q == S_OUT);
  assign out_data      = odata_q;
  assign out_err_mask  = omask_q;
  assign out_err_count = ocnt_q;
  assign busy          = (state_q != S_IDLE);
  assign stat_words    = stat_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bch_error_injector.sv
// Bench for bch_error_injector: directed steps plus random words, checked against
// a behavioural model of the free-running LFSR and the pick/reject rules.
module tb_bch_error_injector;

  localparam int          N       = 15;
  localparam int          MAX_ERR = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic         clk;
  logic         rst;
  logic         cfg_enable;
  logic [7:0]   cfg_num_errors;
  logic         cfg_seed_load;
  logic [15:0]  cfg_seed;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [N-1:0] out_err_mask;
  logic [3:0]   out_err_count;
  logic         busy;
  logic [15:0]  stat_words;
  logic [1:0]   dbg_state;

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_words = 0;
  logic [15:0] m_lfsr;

  bch_error_injector #(.N(N), .MAX_ERR(MAX_ERR), .SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_num_errors(cfg_num_errors),
    .cfg_seed_load(cfg_seed_load), .cfg_seed(cfg_seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_mask(out_err_mask), .out_err_count(out_err_count),
    .busy(busy), .stat_words(stat_words), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] step16(input logic [15:0] s);
    logic [15:0] h;
    h = s / 16'd2;
    return (s % 16'd2 == 16'd1) ? (h ^ 16'hB400) : h;
  endfunction

  // Free-running generator model; seed loads are only driven while the block is idle.
  always @(posedge clk or posedge rst) begin
    if (rst)                m_lfsr <= SEED;
    else if (cfg_seed_load) m_lfsr <= (cfg_seed == 16'h0000) ? SEED : cfg_seed;
    else                    m_lfsr <= step16(m_lfsr);
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Candidate sequence starting one step after the handshake value l0.
  task automatic model_pick(input logic [15:0] l0, input int tgt,
                            output logic [N-1:0] mask, output int lat);
    bit used [16];
    logic [15:0] s;
    int cnt, rej, p;
    bit done;
    for (int i = 0; i < 16; i++) used[i] = 0;
    s = step16(l0); cnt = 0; rej = 0; lat = 0;
    while (cnt < tgt) begin
      p = int'(s % 16'd16);
      if (p < N && !used[p]) begin
        used[p] = 1; cnt++; rej = 0;
      end else if (rej == 63) begin
        done = 0;
        for (int i = 0; i < N; i++) if (!done && !used[i]) begin used[i] = 1; done = 1; end
        cnt++; rej = 0;
      end else begin
        rej++;
      end
      lat++;
      s = step16(s);
    end
    mask = '0;
    for (int i = 0; i < N; i++) if (used[i]) mask[i] = 1'b1;
  endtask

  task automatic seed_load(input logic [15:0] v);
    cfg_seed = v; cfg_seed_load = 1'b1;
    @(negedge clk);
    cfg_seed_load = 1'b0;
  endtask

  // Called just after a negedge with the block idle; returns what the DUT presented.
  task automatic run_word(input string tag, input logic [N-1:0] data, input logic en,
                          input logic [7:0] num, input int hold,
                          output logic [N-1:0] got_mask, output int got_lat);
    logic [N-1:0] emask;
    int tgt, lat, c;
    check(tag, "in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = data; cfg_enable = en; cfg_num_errors = num;
    tgt = en ? ((num > MAX_ERR) ? MAX_ERR : int'(num)) : 0;
    model_pick(m_lfsr, tgt, emask, lat);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = N'($urandom); cfg_enable = 1'($urandom); cfg_num_errors = 8'($urandom);
    c = 0;
    while (!out_valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    got_mask = out_err_mask; got_lat = c;
    check(tag, "latency", c, lat);
    check(tag, "out_data", out_data, data ^ emask);
    check(tag, "out_err_mask", out_err_mask, emask);
    check(tag, "out_err_count", out_err_count, tgt);
    check(tag, "popcount", $countones(out_err_mask), tgt);
    check(tag, "in_ready_busy", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check(tag, "hold_valid", out_valid, 1);
      check(tag, "hold_data", out_data, data ^ emask);
      check(tag, "hold_mask", out_err_mask, emask);
      check(tag, "hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_words++;
    check(tag, "stat_words", stat_words, exp_words);
    check(tag, "out_valid_after", out_valid, 0);
    check(tag, "in_ready_after", in_ready, 1);
    check(tag, "busy_after", busy, 0);
  endtask

  initial begin
    logic [N-1:0] gm;
    int gl;
    rst = 1'b1; cfg_enable = 1'b0; cfg_num_errors = 8'd0; cfg_seed_load = 1'b0;
    cfg_seed = 16'h0000; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset", "in_ready", in_ready, 0);
    check("reset", "out_valid", out_valid, 0);
    check("reset", "busy", busy, 0);
    check("reset", "stat_words", stat_words, 0);
    check("reset", "out_data", out_data, 0);
    check("reset", "out_err_mask", out_err_mask, 0);
    check("reset", "out_err_count", out_err_count, 0);
    rst = 1'b0;
    #1;
    check("reset", "in_ready_release", in_ready, 1);

    run_word("pass", 15'h2A5D, 1'b0, 8'd0, 0, gm, gl);
    run_word("zero_num", 15'h1234, 1'b1, 8'd0, 0, gm, gl);

    seed_load(SEED);
    run_word("two", 15'h2A5D, 1'b1, 8'd2, 0, gm, gl);
    check("two", "mask_const", gm, 15'h0101);
    check("two", "lat_const", gl, 2);

    seed_load(16'h0000);
    run_word("sat", N'($urandom), 1'b1, 8'd200, 0, gm, gl);

    run_word("bp", N'($urandom), 1'b1, 8'd3, 10, gm, gl);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) seed_load(16'($urandom));
      run_word("rand", N'($urandom), 1'($urandom_range(0, 3) != 0),
               8'($urandom_range(0, 6)), $urandom_range(0, 3), gm, gl);
    end

    // Reset in the middle of a four-error pick.
    in_valid = 1'b1; in_data = 15'h5555; cfg_enable = 1'b1; cfg_num_errors = 8'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_pick", "busy_before", busy, 1);
    rst = 1'b1;
    #1;
    exp_words = 0;
    check("rst_pick", "busy", busy, 0);
    check("rst_pick", "out_valid", out_valid, 0);
    check("rst_pick", "stat_words", stat_words, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_pick", "out_valid_held", out_valid, 0);
    end
    rst = 1'b0;
    #1;
    run_word("after_rst", 15'h2A5D, 1'b1, 8'd2, 0, gm, gl);
    check("after_rst", "mask_const", gm, 15'h0101);
    check("after_rst", "lat_const", gl, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bch_error_injector.md
# bch_error_injector

Channel-error stage between the BCH encoder and the BCH syndrome decoder. It accepts one 15-bit codeword, flips a configurable number of distinct bit positions chosen by a free-running LFSR, and presents the corrupted word with its error mask. The error mask lets the decoder stage and the bench check corrections. The block implements the GENERATE_ERRORS step of the transmission flow as a real handshaked pipeline stage.

## Interface
- N, 15, codeword width in bits (legal range 2..16).
- MAX_ERR, 4, maximum number of injected errors per word (must be ≤ N).
- SEED, 16'hACE1, LFSR reset and fallback seed (nonzero).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_enable  in  1  1 = inject errors; 0 = pass the word through unchanged.
- cfg_num_errors  in  8  requested error count; saturates to MAX_ERR.
- cfg_seed_load  in  1  pulse that loads cfg_seed into the LFSR.
- cfg_seed  in  16  seed value; 0 is replaced by SEED.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  block can accept a word.
- in_data  in  N  encoded codeword.
- out_valid  out  1  corrupted word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  N  in_data XOR out_err_mask.
- out_err_mask  out  N  1 in each flipped position.
- out_err_count  out  4  number of bits flipped (popcount of the mask).
- busy  out  1  state ≠ IDLE.
- stat_words  out  16  completed output handshakes; wraps at 16'hFFFF→0.

## Operation
- LFSR: 16-bit Galois, right shift, taps 16'hB400.
  - Each step: lsb = s[0]; s = s>>1; if lsb then s ^= 16'hB400.
  - Advances every cycle after reset, including IDLE and OUT.
  - cfg_seed_load is honoured only in IDLE. It replaces that cycle's step. It is ignored in other states.
- States:
  - **IDLE:** in_ready=1. When in_valid & in_ready:
    - capture in_data;
    - clear mask, count and reject counter;
    - latch target = cfg_enable ? min(cfg_num_errors, MAX_ERR) : 0;
    - go to PICK if target > 0, else go to OUT.
  - **PICK:** candidate pos = lfsr[3:0] (current value, before this cycle's step).
    - Accept if pos < N and mask[pos]==0: set mask[pos], count++, clear the reject counter.
    - Otherwise reject: reject counter++.
    - After 63 consecutive rejects, the 64th evaluation accepts the lowest-index unused bit instead.
    - When count reaches target, go to OUT on that same edge. Load out_data = word ^ final mask and out_err_mask = final mask.
  - **OUT:** out_valid=1. out_data, out_err_mask and out_err_count are held stable.
    - On out_valid & out_ready: stat_words++, go to IDLE.
- cfg_* changes after acceptance do not affect the word in flight.
- Positions are always distinct, so out_err_count always equals popcount(out_err_mask).

## Timing
- Reset values:
  - outputs: in_ready=0 during reset, 1 in the first cycle after rst deasserts; out_valid=0; out_data=0; out_err_mask=0; out_err_count=0; busy=0; stat_words=0;
  - internal: lfsr=SEED, state=IDLE.
- Latency: the input handshake happens at edge T. out_valid is first high in the cycle after edge T+k+r, where k = target and r = rejected candidates.
  - Passthrough (k=0) gives out_valid in the cycle after the handshake.
- No overlap: in_ready=0 from the acceptance edge until the edge of the output handshake.
  - The earliest next acceptance is the cycle after the output handshake, so throughput is ≤ 1 word per (2+k+r) cycles.
- Backpressure: while out_ready=0, the OUT state persists indefinitely with outputs constant.
- rst asserted in any state, including mid-PICK or OUT with out_valid high:
  - the in-flight word is dropped;
  - all registers return to their reset values immediately.
- cfg_num_errors=0 with cfg_enable=1 behaves exactly as cfg_enable=0.

## Test plan
- Reset: hold rst for 3 cycles, then release → out_valid=0, busy=0, stat_words=0, in_ready=1 in the first cycle after release.
- Passthrough: cfg_enable=0, in_data=15'h2A5D → out_data=15'h2A5D, out_err_mask=0, out_err_count=0, out_valid in the cycle after the handshake.
- Two errors:
  - Setup: cfg_enable=1, cfg_num_errors=2, LFSR at SEED, in_data=15'h2A5D.
  - Required: out_err_count=2, popcount(mask)=2, out_data^15'h2A5D==mask.
  - Positions and latency match a cycle-accurate LFSR reference model.
- Saturation and seed: load cfg_seed=0, then inject with cfg_num_errors=200 → the LFSR takes SEED, out_err_count=4, 4 distinct bits are flipped, all positions < 15.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises → out_data and out_err_mask stay constant, in_ready=0.
  - Raise out_ready → handshake, stat_words increments by 1, in_ready=1 on the next cycle.
- Reset mid-PICK: assert rst while busy=1 with cfg_num_errors=4 → out_valid never rises for that word. The next word reproduces the mask sequence from SEED.
